// File: rtl/banked_ram_if.sv
// Request/response bus plus clear control shared between banked_ram and its client.
interface banked_ram_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    clear;
  logic                    busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, clear,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, clear,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/banked_ram.sv
// Single-port RAM split into NUM_BANKS contiguous banks, with registered reads,
// byte-enable writes and a clear engine that zeroes every row after reset or on request.
module banked_ram #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANKS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  banked_ram_if.slave bus
);
  localparam int BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int ROW_BITS   = ADDR_WIDTH - BANK_BITS;
  localparam int BANK_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W      = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int BANK_DEPTH = 2 ** ROW_BITS;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BANK_DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ROW_W-1:0]      r_clr_cnt;
  logic [ROW_W-1:0]      w_next_cnt;
  logic                  w_busy;
  logic                  w_ready;
  logic                  w_clr_we;
  logic [BANK_W-1:0]     w_bank;
  logic [ROW_W-1:0]      w_row;
  logic                  w_wr;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_sel_rdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  // Bank = top address bits, row = the rest; a single bank uses the whole address as row.
  generate
    if (BANK_BITS > 0) begin : g_bank_sel
      assign w_bank      = bus.req_addr[ADDR_WIDTH-1 -: BANK_BITS];
      assign w_sel_rdata = w_bank_rdata[w_bank];
    end else begin : g_single_bank
      assign w_bank      = '0;
      assign w_sel_rdata = w_bank_rdata[0];
    end
    if (ROW_BITS > 0) begin : g_row
      assign w_row = bus.req_addr[ROW_BITS-1:0];
    end else begin : g_no_row
      assign w_row = '0;
    end
  endgenerate

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_clr_cnt <= w_next_cnt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_clr_cnt;
    w_busy       = 1'b0;
    w_ready      = 1'b0;
    w_clr_we     = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        w_busy     = 1'b1;
        w_clr_we   = 1'b1;
        w_next_cnt = r_clr_cnt + ROW_W'(1);
        if (r_clr_cnt == LAST_ROW) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end
      end
      ST_IDLE: begin
        w_ready = !bus.clear;
        if (bus.clear) begin
          w_next_state = ST_CLEAR;
          w_next_cnt   = '0;
        end
      end
      default: w_next_state = ST_CLEAR;
    endcase
  end

  assign w_wr = bus.req_valid && w_ready && bus.req_we;
  assign w_rd = bus.req_valid && w_ready && !bus.req_we;

  // NOTE: storage has no reset; the clear engine zeroes it row by row instead.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];

    always_ff @(posedge clk) begin
      if (w_clr_we) begin
        r_mem[r_clr_cnt] <= '0;
      end else if (w_wr && (w_bank == BANK_W'(b))) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (bus.req_be[i]) r_mem[w_row][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end

    assign w_bank_rdata[b] = r_mem[w_row];
  end

  // Read data is held between responses; only an accepted read reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd;
      if (w_rd) r_rsp_rdata <= w_sel_rdata;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
- Parametrised single-port synchronous RAM split into NUM_BANKS equal banks, with separate write and read data buses and a valid/ready request handshake.
- Registered read (1-cycle latency) and per-byte write enables.
- Built-in clear engine zeroes every location after reset or on request.
- Serves as the general data/instruction store for the processor datapath and replaces fixed-size tristate-bus RAMs.

Parameters:
- ADDR_WIDTH, 14, word address width; total depth 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, word width; must be a multiple of 8.
- NUM_BANKS, 4, power of two, at least 1 and at most 2**ADDR_WIDTH; bank = top log2(NUM_BANKS) address bits.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at clk rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte enables, bit i covers bits [8i+7:8i]; ignored on reads.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_rdata  out  DATA_WIDTH  read data; holds last value until the next read response.
- clear  in  1  request full-memory zeroing.
- busy  out  1  clear engine active.

Behaviour:
- BANK_DEPTH = 2**ADDR_WIDTH / NUM_BANKS. Bank index = req_addr[ADDR_WIDTH-1 -: log2(NUM_BANKS)]. Row = remaining low bits. When NUM_BANKS = 1, the whole address is the row.
- FSM has two states, CLEAR and IDLE.
- Reset: state = CLEAR, clear counter = 0, busy = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0.
- CLEAR state:
  - Each cycle writes 0 to the counter row in all banks in parallel, then increments the counter.
  - On the cycle the counter reaches BANK_DEPTH-1, the next state is IDLE.
  - Clear therefore takes exactly BANK_DEPTH cycles; busy is high for that whole period.
- IDLE state:
  - busy = 0.
  - req_ready = !clear (combinational).
  - If clear = 1: next state = CLEAR, counter = 0, and any simultaneous request is not accepted. Clear wins.
  - clear held high in CLEAR has no further effect; the engine does not restart.
- Write accepted: each byte with req_be[i] = 1 is updated at that edge; other bytes are unchanged. be = 0 means no change. No response is generated.
- Read accepted at edge N: rsp_valid = 1 and rsp_rdata = mem[addr] during the cycle after edge N. rsp_valid returns to 0 unless another read is accepted at edge N+1.
- Full throughput: one request per cycle, any mix of reads and writes.
- Read-after-write to the same address on consecutive cycles returns the new data.
- A read accepted on the same edge that clear is sampled cannot happen, because ready is low. A read accepted the edge before clear still completes, returning pre-clear data.
- Reset asserted mid-clear restarts the counter at 0; the full BANK_DEPTH cycles are needed again.
- Reset mid-read: rsp_valid = 0 on the next cycle and the response is lost. Memory contents are then zeroed by the clear.
- Address wrap: none. Every address is valid and banks are contiguous. Address 2**ADDR_WIDTH-1 is the last row of the last bank.

Test Plan:
- Reset, defaults -> busy = 1 and req_ready = 0 for exactly 4096 cycles, then busy = 0. A read of 0x3FFF then gives rsp_rdata = 0x0000 with rsp_valid one cycle later.
- Bank-boundary writes with be = 2'b11:
  - Writes of distinct random data to 0x0FFC–0x0FFF, 0x1FFC–0x1FFF, 0x2FFC–0x2FFF, 0x3FFC–0x3FFF, then back-to-back reads -> each returns its own data with 1-cycle latency and rsp_valid high on consecutive cycles. Addresses 0x1000 and 0x3000 still read 0x0000.
- Byte enables:
  - Write 0xABCD to 0x2000 with be = 11, then write 0x1234 with be = 01 -> read gives 0xAB34.
  - A further write with be = 00 leaves the word at 0xAB34.
- Back-to-back sequence write 0x5555 @0x0010, read @0x0010, write 0xAAAA @0x0010, read @0x0010 -> responses 0x5555 then 0xAAAA, with no stall (req_ready high throughout).
- Clear with a pending request:
  - Assert clear together with req_valid (write 0xFFFF @0x0001) -> req_ready = 0 that cycle, busy high for 4096 cycles, and the write is dropped.
  - After clear completes, a read of 0x0001 gives 0x0000 and a read of 0x2000 gives 0x0000.
- Reset at clear cycle 100 -> busy stays high for a further 4096 cycles from the reset edge. Repeat with NUM_BANKS = 1 and NUM_BANKS = 8, DATA_WIDTH = 32 -> clear lengths 16384 and 2048 cycles respectively.
